// File: rtl/regfile_scoreboard.sv
// General-purpose register file with three registered read ports, a formatted
// primary write port, an update write port and a per-register busy scoreboard.
module regfile_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   ra_addr,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] ra_data,
  output logic [XLEN-1:0] rb_data,
  output logic            rs_busy,
  output logic            ra_busy,
  output logic            rb_busy,
  output logic            rd_valid,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic [1:0]      wa_size,
  input  logic            wa_sext,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            resv_en,
  input  logic [AW-1:0]   resv_addr,
  output logic            resv_conflict
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [NREGS-1:0] w_busy_nxt;
  logic [XLEN-1:0]  w_wa_val;
  logic             w_wa_ok;
  logic             w_wb_ok;
  logic             w_resv_ok;
  logic             w_resv_clr;
  logic             w_conflict;
  logic [AW-1:0]    w_raddr [3];
  logic [XLEN-1:0]  w_rdata [3];
  logic [2:0]       w_rbusy;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  // Shift the chosen field to the top, then shift back arithmetically or
  // logically; a zero shift covers double (and word when XLEN is 32).
  function automatic logic [XLEN-1:0] fmt_wa(input logic [XLEN-1:0] d,
                                             input logic [1:0] sz,
                                             input logic sx);
    logic signed [XLEN-1:0] t;
    int sh;
    case (sz)
      2'b00:   sh = XLEN - 8;
      2'b01:   sh = XLEN - 16;
      2'b10:   sh = XLEN - 32;
      default: sh = 0;
    endcase
    t = d << sh;
    return sx ? t >>> sh : t >> sh;
  endfunction

  assign w_wa_val   = fmt_wa(wa_data, wa_size, wa_sext);
  assign w_wa_ok    = wa_en && in_range(wa_addr);
  assign w_wb_ok    = wb_en && in_range(wb_addr) && !(w_wa_ok && wb_addr == wa_addr);
  assign w_resv_ok  = resv_en && in_range(resv_addr);
  assign w_resv_clr = (w_wa_ok && wa_addr == resv_addr) || (w_wb_ok && wb_addr == resv_addr);
  assign w_conflict = w_resv_ok && r_busy[resv_addr] && !w_resv_clr;

  assign w_raddr[0] = rs_addr;
  assign w_raddr[1] = ra_addr;
  assign w_raddr[2] = rb_addr;

  // A new reservation overrides a same-edge clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wa_ok)   w_busy_nxt[wa_addr]   = 1'b0;
    if (w_wb_ok)   w_busy_nxt[wb_addr]   = 1'b0;
    if (w_resv_ok) w_busy_nxt[resv_addr] = 1'b1;
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_rdata[p] = '0;
      w_rbusy[p] = 1'b0;
      if (in_range(w_raddr[p])) begin
        w_rdata[p] = r_regs[w_raddr[p]];
        w_rbusy[p] = r_busy[w_raddr[p]];
        if (BYPASS != 0) begin
          w_rbusy[p] = w_busy_nxt[w_raddr[p]];
          if (w_wa_ok && wa_addr == w_raddr[p])      w_rdata[p] = w_wa_val;
          else if (w_wb_ok && wb_addr == w_raddr[p]) w_rdata[p] = wb_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy        <= '0;
      rs_data       <= '0;
      ra_data       <= '0;
      rb_data       <= '0;
      rs_busy       <= 1'b0;
      ra_busy       <= 1'b0;
      rb_busy       <= 1'b0;
      rd_valid      <= 1'b0;
      resv_conflict <= 1'b0;
    end else begin
      if (w_wa_ok) r_regs[wa_addr] <= w_wa_val;
      if (w_wb_ok) r_regs[wb_addr] <= wb_data;
      r_busy        <= w_busy_nxt;
      rd_valid      <= rd_en;
      resv_conflict <= w_conflict;
      if (rd_en) begin
        rs_data <= w_rdata[0];
        ra_data <= w_rdata[1];
        rb_data <= w_rdata[2];
        rs_busy <= w_rbusy[0];
        ra_busy <= w_rbusy[1];
        rb_busy <= w_rbusy[2];
      end
    end
  end

endmodule
